seq_pattern_tx: RTL and testbench

Serial pattern transmitter: on a start request it latches a PAT_W-bit pattern and a repetition count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of repetitions. It produces the stimulus side of the team's serial sequence-detector path (default pattern 1011). It is used both as a bench/BIST source and as an on-chip framing-pattern generator.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_shreg.sv | 40 ++++
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern path (transmitter and detector).
// Holds the FSM state type and the single definition of the default pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [3:0] SEQ_DEF_PAT = 4'b1011;

endpackage

// File: rtl/seq_shreg.sv
// Parallel-load, shift-left register. Load has priority over shift;
// a zero enters at bit 0 on every shift. msb is the top bit.
module seq_shreg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] q_reg;
    logic [PAT_W-1:0] q_next;

    // Per-bit next-state selection: load, shift from the bit below, or hold.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign q_next[gi] = load ? din[gi] : (shift ? 1'b0 : q_reg[gi]);
            end else begin : g_upper
                assign q_next[gi] = load ? din[gi] : (shift ? q_reg[gi-1] : q_reg[gi]);
            end
        end
    endgenerate

    // Storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign msb = q_reg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern and repetition count on start,
// then sends the pattern MSB-first, one bit per clock, R times.
// Optional feature macro: GAP_EN inserts one idle cycle between repetitions.
// All outputs are flops; the shift register holds the bits still to come
// after the one currently on outp, so outp can be loaded from its msb.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    output logic             outp,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int               BC_W   = $clog2(PAT_W);
    localparam logic [BC_W-1:0]  BC_MAX = BC_W'(PAT_W - 1);

    seq_state_t       state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic             outp_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [PAT_W-1:0] sel_pat;
    logic [PAT_W-1:0] load_src;
    logic             accept;
    logic             last_bit;
    logic             reload;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;

    // Request qualification and shift-register control.
    always_comb begin
        sel_pat  = use_def ? DEF_PAT : pat_in;
        accept   = (state_reg == IDLE) && start && (rep_in != '0);
        last_bit = (state_reg == SEND) && (bit_cnt_reg == '0);
        reload   = last_bit && (rep_cnt_reg != CNT_W'(1));
        load_src = (state_reg == IDLE) ? sel_pat : pat_reg;
        sh_load  = accept || reload;
        sh_shift = (state_reg == SEND) && (bit_cnt_reg != '0);
    end

    // The register is loaded with the pattern minus its first bit, which goes
    // straight to outp on the same edge.
    seq_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   ({load_src[PAT_W-2:0], 1'b0}),
        .msb   (sh_msb)
    );

    // Transfer FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pat_reg       <= '0;
            rep_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            outp_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pat_reg       <= sel_pat;
                        rep_cnt_reg   <= rep_in;
                        bit_cnt_reg   <= BC_MAX;
                        outp_reg      <= sel_pat[PAT_W-1];
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt_reg == '0) begin
                        if (rep_cnt_reg == CNT_W'(1)) begin
                            outp_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
                            bit_cnt_reg <= BC_MAX;
`ifdef GAP_EN
                            outp_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            state_reg     <= GAP;
`else
                            outp_reg      <= pat_reg[PAT_W-1];
`endif
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg - BC_W'(1);
                        outp_reg    <= sh_msb;
                    end
                end
`ifdef GAP_EN
                GAP: begin
                    outp_reg      <= pat_reg[PAT_W-1];
                    out_valid_reg <= 1'b1;
                    state_reg     <= SEND;
                end
`endif
                default: begin
                    outp_reg      <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign outp      = outp_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes expected bits and done
// pulses into queues; a negedge monitor pops and compares them.
module tb_seq_pattern_tx;

`ifdef GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       use_def = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] rep_in = 4'd0;
    logic       outp;
    logic       out_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    bit exp_bits[$];
    int exp_done[$];
    int done_seen = 0;

    seq_pattern_tx #(
        .PAT_W   (4),
        .CNT_W   (4),
        .DEF_PAT (4'b1011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .use_def   (use_def),
        .pat_in    (pat_in),
        .rep_in    (rep_in),
        .outp      (outp),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    // Monitor: compare every valid bit and every done pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL bit: got %0b expected none (queue empty) at %0t", outp, $time);
                end else begin
                    bit e;
                    e = exp_bits.pop_front();
                    if (outp !== e) begin
                        errors++;
                        $display("FAIL bit: got %0b expected %0b at %0t", outp, e, $time);
                    end else begin
                        $display("ok   bit: %0b at %0t", outp, $time);
                    end
                end
            end
            if (done) begin
                checks++;
                done_seen++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done: got unexpected pulse expected none at %0t", $time);
                end else begin
                    void'(exp_done.pop_front());
                    if (busy !== 1'b0 || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL done_idle: got busy=%0b valid=%0b expected 0/0 at %0t",
                                 busy, out_valid, $time);
                    end else begin
                        $display("ok   done pulse at %0t", $time);
                    end
                end
            end
        end
    end

    task automatic push_pat(input logic [3:0] p, input int rep);
        for (int r = 0; r < rep; r++) begin
            for (int i = 3; i >= 0; i--) begin
                exp_bits.push_back(p[i]);
            end
        end
    endtask

    // Issue one transfer, then measure busy length and gap cycles.
    task automatic run_xfer(input string name, input logic ud, input logic [3:0] p,
                            input int rep, input bit disturb);
        int cnt;
        int gaps;
        logic [3:0] eff;
        eff = ud ? 4'b1011 : p;
        push_pat(eff, rep);
        exp_done.push_back(1);
        @(posedge clk); #1;
        start = 1'b1; use_def = ud; pat_in = p; rep_in = 4'(rep);
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        gaps = 0;
        while (busy && cnt < 300) begin
            cnt++;
            if (!out_valid) begin
                gaps++;
                chk({name, "_gap_outp"}, int'(outp), 0);
            end
            if (disturb && cnt == 1) begin
                start = 1'b1; pat_in = ~p; use_def = ~ud; rep_in = 4'd7;
            end
            if (disturb && cnt == 3) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({name, "_busy_len"}, cnt, rep * (4 + G) - G);
        chk({name, "_gaps"}, gaps, (rep - 1) * G);
        chk({name, "_done"}, int'(done), 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_bits.size() != 0 || exp_done.size() != 0) && t < 50) begin
            @(posedge clk);
            t++;
        end
    endtask

    initial begin
        int cnt;
        int dseen;
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_outp", int'(outp), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: default pattern, single repetition
        run_xfer("t1_def_r1", 1'b1, 4'b0000, 1, 1'b0);
        drain();

        // 2: custom pattern, three repetitions
        run_xfer("t2_0110_r3", 1'b0, 4'b0110, 3, 1'b0);
        drain();

        // 3: default pattern, two repetitions (gap count depends on GAP_EN)
        run_xfer("t3_def_r2", 1'b1, 4'b0000, 2, 1'b0);
        drain();

        // 4a: R = 0 is ignored
        dseen = done_seen;
        @(posedge clk); #1;
        start = 1'b1; use_def = 1'b1; rep_in = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4a_busy_0", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4a_still_idle", int'(busy), 0);
        chk("t4a_no_done", done_seen - dseen, 0);

        // 4b: inputs changed and start re-asserted mid-transfer
        run_xfer("t4b_disturb", 1'b0, 4'b1001, 2, 1'b1);
        drain();

        // 5: asynchronous reset during bit 2 of R = 2
        dseen = done_seen;
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        @(posedge clk); #1;
        start = 1'b1; use_def = 1'b1; rep_in = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_outp", int'(outp), 0);
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("t5_no_done", done_seen - dseen, 0);
        chk("t5_q_flushed", exp_bits.size(), 0);
        run_xfer("t5_after_rst", 1'b1, 4'b0000, 2, 1'b0);
        drain();

        // 6: back-to-back, start held across the done cycle
        push_pat(4'b0110, 1);
        push_pat(4'b1100, 1);
        exp_done.push_back(1);
        exp_done.push_back(2);
        @(posedge clk); #1;
        start = 1'b1; use_def = 1'b0; pat_in = 4'b0110; rep_in = 4'd1;
        @(posedge clk); #1;
        pat_in = 4'b1100;
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("t6_first_len", cnt, 4);
        chk("t6_first_done", int'(done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_second_busy", int'(busy), 1);
        chk("t6_second_first_bit", int'(outp), 1);
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("t6_second_len", cnt, 4);
        chk("t6_second_done", int'(done), 1);
        drain();

        chk("end_bits_left", exp_bits.size(), 0);
        chk("end_done_left", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
